// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: MEM->WB bus field offsets,
// exception codes and the TID CSR index.
package wb_pkg;
    localparam int ADEF_BIT    = 206;
    localparam int INE_BIT     = 205;
    localparam int ALE_BIT     = 204;
    localparam int BADV_LSB    = 172;
    localparam int BRK_BIT     = 171;
    localparam int RDCNTID_BIT = 170;
    localparam int RDCNTVL_BIT = 169;
    localparam int RDCNTVH_BIT = 168;
    localparam int EXCODE_LSB  = 153;
    localparam int RJ_LSB      = 121;
    localparam int RKD_LSB     = 89;
    localparam int SYSCALL_BIT = 88;
    localparam int ERTN_BIT    = 87;
    localparam int CSRRD_BIT   = 86;
    localparam int CSRWR_BIT   = 85;
    localparam int CSRXCHG_BIT = 84;
    localparam int CSRNUM_LSB  = 70;
    localparam int PC_LSB      = 38;
    localparam int GRWE_BIT    = 37;
    localparam int DEST_LSB    = 32;
    localparam int RESULT_LSB  = 0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [13:0] CSR_TID = 14'h40;
endpackage

// File: rtl/wb_exc_encode.sv
// Priority encoder for writeback exceptions: INT > ADEF > INE > SYS > BRK > ALE.
module wb_exc_encode
    import wb_pkg::*;
(
    input  logic       i_has_int,
    input  logic       i_adef,
    input  logic       i_ine,
    input  logic       i_syscall,
    input  logic       i_brk,
    input  logic       i_ale,
    output logic       o_ex,
    output logic [5:0] o_ecode,
    output logic [8:0] o_esubcode
);
    always_comb begin
        o_ex       = 1'b1;
        o_ecode    = ECODE_INT;
        o_esubcode = 9'd0;
        if (i_has_int)      o_ecode = ECODE_INT;
        else if (i_adef)    o_ecode = ECODE_ADEF;
        else if (i_ine)     o_ecode = ECODE_INE;
        else if (i_syscall) o_ecode = ECODE_SYS;
        else if (i_brk)     o_ecode = ECODE_BRK;
        else if (i_ale)     o_ecode = ECODE_ALE;
        else                o_ex    = 1'b0;
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: commits regfile/CSR writes, resolves exceptions and ertn
// into one flush, owns the 64-bit stable counter. Option: WB_DEBUG_TRACE_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int BUS_W   = 207,
    parameter int TIMER_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MEM_to_WB_valid,
    input  logic [BUS_W-1:0] MEM_to_WB_bus,
    output logic             WB_allowin,
    input  logic             has_int,
    input  logic [31:0]      csr_rvalue,
    input  logic [31:0]      ex_entry,
    input  logic [31:0]      era_value,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             csr_we,
    output logic [13:0]      csr_num,
    output logic [31:0]      csr_wmask,
    output logic [31:0]      csr_wvalue,
    output logic             wb_ex,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_vaddr,
    output logic             ertn_flush,
    output logic             exec_flush,
    output logic [31:0]      flush_target,
    output logic             out_WB_valid
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
`endif
);
    logic               r_valid;
    logic [BUS_W-1:0]   r_bus;
    logic [TIMER_W-1:0] r_timer;

    logic       w_enc_ex;
    logic [5:0] w_enc_ecode;
    logic [8:0] w_enc_esubcode;
    logic       w_ex;
    logic       w_csr_read;
    logic       w_unused;

    // ready_go is constant 1, so WB always accepts.
    assign WB_allowin = 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else begin
            if (exec_flush)
                r_valid <= 1'b0;
            else if (WB_allowin)
                r_valid <= MEM_to_WB_valid;
            if (WB_allowin && MEM_to_WB_valid)
                r_bus <= MEM_to_WB_bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_timer <= '0;
        else
            r_timer <= r_timer + TIMER_W'(1);
    end

    wb_exc_encode u_exc (
        .i_has_int  (has_int),
        .i_adef     (r_bus[ADEF_BIT]),
        .i_ine      (r_bus[INE_BIT]),
        .i_syscall  (r_bus[SYSCALL_BIT]),
        .i_brk      (r_bus[BRK_BIT]),
        .i_ale      (r_bus[ALE_BIT]),
        .o_ex       (w_enc_ex),
        .o_ecode    (w_enc_ecode),
        .o_esubcode (w_enc_esubcode)
    );

    assign w_ex         = r_valid & w_enc_ex;
    assign wb_ex        = w_ex;
    assign wb_ecode     = w_ex ? w_enc_ecode : 6'd0;
    assign wb_esubcode  = w_ex ? w_enc_esubcode : 9'd0;
    assign wb_vaddr     = (w_ex && (w_enc_ecode == ECODE_ADEF || w_enc_ecode == ECODE_ALE))
                          ? r_bus[BADV_LSB +: 32] : 32'd0;
    assign ertn_flush   = r_valid & r_bus[ERTN_BIT] & ~w_ex;
    assign exec_flush   = w_ex | ertn_flush;
    assign flush_target = w_ex ? ex_entry : era_value;
    assign wb_pc        = r_bus[PC_LSB +: 32];
    assign out_WB_valid = r_valid;

    assign rf_we    = r_valid & r_bus[GRWE_BIT] & ~w_ex & (r_bus[DEST_LSB +: 5] != 5'd0);
    assign rf_waddr = r_bus[DEST_LSB +: 5];

    assign w_csr_read = r_bus[CSRRD_BIT] | r_bus[CSRWR_BIT] | r_bus[CSRXCHG_BIT] | r_bus[RDCNTID_BIT];

    always_comb begin
        if (r_bus[RDCNTVL_BIT])
            rf_wdata = r_timer[31:0];
        else if (r_bus[RDCNTVH_BIT])
            rf_wdata = r_timer[TIMER_W-1 -: 32];
        else if (w_csr_read)
            rf_wdata = csr_rvalue;
        else
            rf_wdata = r_bus[RESULT_LSB +: 32];
    end

    assign csr_we     = r_valid & (r_bus[CSRWR_BIT] | r_bus[CSRXCHG_BIT]) & ~w_ex;
    // Mask is forced to 0 on an empty stage so nothing stale leaks out after reset.
    assign csr_wmask  = !r_valid ? 32'd0 :
                        r_bus[CSRXCHG_BIT] ? r_bus[RJ_LSB +: 32] : 32'hFFFF_FFFF;
    assign csr_wvalue = r_bus[RKD_LSB +: 32];
    assign csr_num    = r_bus[RDCNTID_BIT] ? CSR_TID : r_bus[CSRNUM_LSB +: 14];

    // ex_code is carried on the bus but never consumed here.
    assign w_unused = ^r_bus[EXCODE_LSB +: 15];

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif
endmodule
